piso_shift_tx: RTL and testbench

- Parallel-in, serial-out transmit register: the sending end for the serial left-shift loading path (D_IN + SHIFT_L) of the parallel load register.
- Accepts a REG_SIZE-bit word through a load handshake, then emits it MSB-first on D_OUT, one bit per enabled clock.
- Framing outputs D_VALID and LAST let a downstream shift register know exactly when to assert its shift-enable.

---
 rtl/piso_shift_tx_if.sv | 23 ++
 rtl/piso_shift_tx.sv | 138 +++++++++++++
 tb/tb_piso_shift_tx.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/piso_shift_tx_if.sv
// Load handshake and serial framing bundle for piso_shift_tx.
// The transmitter takes the slave side; the word source and serial receiver take the master side.
interface piso_shift_tx_if #(
    parameter int REG_SIZE = 4
) ();
    logic [REG_SIZE-1:0] X;
    logic                LOAD;
    logic                READY;
    logic                SHIFT_L;
    logic                D_OUT;
    logic                D_VALID;
    logic                LAST;

    modport master (
        output X, LOAD, SHIFT_L,
        input  READY, D_OUT, D_VALID, LAST
    );

    modport slave (
        input  X, LOAD, SHIFT_L,
        output READY, D_OUT, D_VALID, LAST
    );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: accepts a word on LOAD && READY, sends it MSB-first with D_VALID/LAST framing.
// Optional feature macro: PISO_TX_PARITY_EN appends an even-parity bit after the data LSB.
module piso_shift_tx #(
    parameter int REG_SIZE = 4
) (
    input  logic            CLOCK,
    input  logic            CLEAR,
    piso_shift_tx_if.slave  bus
);
    localparam int CNT_W = $clog2(REG_SIZE + 1);
`ifdef PISO_TX_PARITY_EN
    localparam int FRAME_LEN = REG_SIZE + 1;
`else
    localparam int FRAME_LEN = REG_SIZE;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [REG_SIZE-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_s;
    logic                ready_s;
    logic                d_out_s;
    logic                accept_s;

`ifdef PISO_TX_PARITY_EN
    logic parity_q, parity_d;

    function automatic logic even_parity(input logic [REG_SIZE-1:0] word);
        return ^word;
    endfunction
`endif

    // Framing outputs decoded from the registered state; READY in SHIFT opens only on the final enabled bit
    always_comb begin
        last_s  = 1'b0;
        ready_s = 1'b1;
        d_out_s = 1'b0;
        case (state_q)
            IDLE: begin
                ready_s = 1'b1;
            end
            SHIFT: begin
                last_s  = (cnt_q == LAST_CNT);
                ready_s = last_s && bus.SHIFT_L;
`ifdef PISO_TX_PARITY_EN
                if (cnt_q == CNT_W'(REG_SIZE)) begin
                    d_out_s = parity_q;
                end else begin
                    d_out_s = sreg_q[REG_SIZE-1];
                end
`else
                d_out_s = sreg_q[REG_SIZE-1];
`endif
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
    end

    assign accept_s    = bus.LOAD && ready_s;
    assign bus.READY   = ready_s;
    assign bus.D_OUT   = d_out_s;
    assign bus.D_VALID = (state_q == SHIFT);
    assign bus.LAST    = last_s;

    // Next-state logic: load, shift, back-to-back reload or return to IDLE; SHIFT_L low freezes a frame
    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
`ifdef PISO_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d  = SHIFT;
                    sreg_d   = bus.X;
                    cnt_d    = {CNT_W{1'b0}};
`ifdef PISO_TX_PARITY_EN
                    parity_d = even_parity(bus.X);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (!bus.SHIFT_L) begin
                    state_d = SHIFT;
                end else if (!last_s) begin
                    sreg_d = {sreg_q[REG_SIZE-2:0], 1'b0};
                    cnt_d  = cnt_q + CNT_W'(1);
                end else if (accept_s) begin
                    sreg_d   = bus.X;
                    cnt_d    = {CNT_W{1'b0}};
`ifdef PISO_TX_PARITY_EN
                    parity_d = even_parity(bus.X);
`endif
                end else begin
                    state_d = IDLE;
                    sreg_d  = {REG_SIZE{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            default: begin
                state_d = IDLE;
                sreg_d  = {REG_SIZE{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State registers; CLEAR aborts any frame in progress immediately
    always_ff @(posedge CLOCK or posedge CLEAR) begin
        if (CLEAR) begin
            state_q  <= IDLE;
            sreg_q   <= {REG_SIZE{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
`ifdef PISO_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
`ifdef PISO_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end
endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx: directed test-plan frames then random traffic,
// every cycle compared against a queue-of-pending-bits reference model.
module tb_piso_shift_tx;
    localparam int REG_SIZE = 4;
`ifdef PISO_TX_PARITY_EN
    localparam int FL = REG_SIZE + 1;
    localparam logic [31:0] E_SINGLE = 32'b11011;
    localparam logic [31:0] E_STALL  = 32'b10001;
    localparam logic [31:0] E_B2B    = 32'b1010001100;
    localparam logic [31:0] E_BUSY   = 32'b01010;
    localparam logic [31:0] E_RST    = 32'b00110;
    localparam logic [31:0] E_1001   = 32'b10010;
`else
    localparam int FL = REG_SIZE;
    localparam logic [31:0] E_SINGLE = 32'b1101;
    localparam logic [31:0] E_STALL  = 32'b1000;
    localparam logic [31:0] E_B2B    = 32'b10100110;
    localparam logic [31:0] E_BUSY   = 32'b0101;
    localparam logic [31:0] E_RST    = 32'b0011;
    localparam logic [31:0] E_1001   = 32'b1001;
`endif

    logic clk = 1'b0;
    logic clear;
    int   checks = 0;
    int   errors = 0;

    // Reference model: bits still to be sent, head is on D_OUT
    logic        q[$];
    logic [31:0] obs;
    int          obs_len;
    int          span;

    piso_shift_tx_if #(.REG_SIZE(REG_SIZE)) bus ();

    piso_shift_tx #(.REG_SIZE(REG_SIZE)) dut (
        .CLOCK (clk),
        .CLEAR (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic chk_v(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clr_obs();
        obs     = 32'd0;
        obs_len = 0;
        span    = 0;
    endtask

    // One clock cycle: drive, compare outputs with the model, advance the model across the edge
    task automatic step(input logic ld, input logic [REG_SIZE-1:0] xv, input logic s);
        logic ev, eo, el, er;
        bus.LOAD    = ld;
        bus.X       = xv;
        bus.SHIFT_L = s;
        #1;
        if (q.size() == 0) begin
            ev = 1'b0; eo = 1'b0; el = 1'b0; er = 1'b1;
        end else begin
            ev = 1'b1; eo = q[0]; el = (q.size() == 1); er = el && s;
        end
        chk("d_valid", bus.D_VALID, ev);
        chk("d_out",   bus.D_OUT,   eo);
        chk("last",    bus.LAST,    el);
        chk("ready",   bus.READY,   er);
        if (bus.D_VALID === 1'b1) begin
            span++;
            if (s) begin
                obs = {obs[30:0], bus.D_OUT};
                obs_len++;
            end
        end
        @(posedge clk);
        if (q.size() != 0 && s) void'(q.pop_front());
        if (ld && er) begin
            for (int i = REG_SIZE - 1; i >= 0; i--) q.push_back(xv[i]);
`ifdef PISO_TX_PARITY_EN
            q.push_back(^xv);
`endif
        end
        #1;
    endtask

    initial begin
        clear       = 1'b1;
        bus.LOAD    = 1'b1;
        bus.X       = 4'b1111;
        bus.SHIFT_L = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_d_valid", bus.D_VALID, 1'b0);
        chk("rst_d_out",   bus.D_OUT,   1'b0);
        chk("rst_last",    bus.LAST,    1'b0);
        chk("rst_ready",   bus.READY,   1'b1);
        #2;
        clear    = 1'b0;
        bus.LOAD = 1'b0;
        @(posedge clk);
        #1;

        // Single frame
        clr_obs();
        step(1'b1, 4'b1101, 1'b1);
        repeat (FL + 1) step(1'b0, 4'b0000, 1'b1);
        chk_v("single_stream", obs, E_SINGLE);
        chk_v("single_len", 32'(obs_len), 32'(FL));

        // Stall for three cycles after two bits
        clr_obs();
        step(1'b1, 4'b1000, 1'b1);
        repeat (2) step(1'b0, 4'b0000, 1'b1);
        repeat (3) step(1'b0, 4'b0000, 1'b0);
        repeat (FL) step(1'b0, 4'b0000, 1'b1);
        chk_v("stall_stream", obs, E_STALL);
        chk_v("stall_span", 32'(span), 32'(FL + 3));

        // Back-to-back reload on the LAST cycle
        clr_obs();
        step(1'b1, 4'b1010, 1'b1);
        repeat (FL - 1) step(1'b0, 4'b0000, 1'b1);
        step(1'b1, 4'b0110, 1'b1);
        repeat (FL + 1) step(1'b0, 4'b0000, 1'b1);
        chk_v("b2b_stream", obs, E_B2B);
        chk_v("b2b_span", 32'(span), 32'(2 * FL));

        // Load pulse while busy is ignored
        clr_obs();
        step(1'b1, 4'b0101, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b1, 4'b1111, 1'b1);
        repeat (FL + 2) step(1'b0, 4'b0000, 1'b1);
        chk_v("busy_stream", obs, E_BUSY);
        chk_v("busy_len", 32'(obs_len), 32'(FL));

        // Asynchronous clear between edges mid-frame
        step(1'b1, 4'b1100, 1'b1);
        repeat (2) step(1'b0, 4'b0000, 1'b1);
        bus.LOAD = 1'b1;
        bus.X    = 4'b1111;
        #1;
        clear = 1'b1;
        #1;
        chk("clr_d_valid", bus.D_VALID, 1'b0);
        chk("clr_ready",   bus.READY,   1'b1);
        chk("clr_last",    bus.LAST,    1'b0);
        q.delete();
        @(posedge clk);
        #3;
        clear    = 1'b0;
        bus.LOAD = 1'b0;
        @(posedge clk);
        #1;
        clr_obs();
        step(1'b1, 4'b0011, 1'b1);
        repeat (FL + 1) step(1'b0, 4'b0000, 1'b1);
        chk_v("rst_frame_stream", obs, E_RST);

        // Word 1001 (parity bit 0 when enabled)
        clr_obs();
        step(1'b1, 4'b1001, 1'b1);
        repeat (FL + 1) step(1'b0, 4'b0000, 1'b1);
        chk_v("w1001_stream", obs, E_1001);

        // Random traffic against the model
        repeat (400) begin
            step(1'($urandom_range(0, 1)), REG_SIZE'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
